// File: rtl/door_access_ctrl.sv
// door_access_ctrl
// Drives the door strike for a shared room. Several requesters (MCU link at
// index 0, keypad, card reader) ask for an unlock; one is answered per cycle
// in round-robin order. The answer depends on the booking state, the
// requester's admin qualifier and whether repeated refusals have put the
// controller into lockout. The door sensor ends the strike window early and
// raises an alarm when the door stays open too long.
module door_access_ctrl #(
    parameter int NREQ        = 3,
    parameter int UNLOCK_CYC  = 150_000_000,
    parameter int AJAR_CYC    = 1_500_000_000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 500_000_000
) (
    input  logic            FPGA_CLK1_50,
    input  logic            reset_n,
    input  logic            available,
    input  logic            unavailable,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] admin,
    input  logic            door_closed,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] deny,
    output logic            lock_output,
    output logic            room_available,
    output logic            ajar_alarm,
    output logic            lockout
);

    // One counter serves every timed state, so it is sized for the longest one.
    localparam int MAX_CYC = (UNLOCK_CYC > AJAR_CYC)
                           ? ((UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC)
                           : ((AJAR_CYC > LOCKOUT_CYC) ? AJAR_CYC : LOCKOUT_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);

    localparam logic [CW-1:0] UNLOCK_LAST  = CW'(UNLOCK_CYC - 1);
    localparam logic [CW-1:0] AJAR_LAST    = CW'(AJAR_CYC - 1);
    localparam logic [CW-1:0] LOCKOUT_LAST = CW'(LOCKOUT_CYC - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAIL);
    localparam logic [PW-1:0] PTR_LAST     = PW'(NREQ - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_UNLOCK  = 2'd1;
    localparam logic [1:0] S_OPEN    = 2'd2;
    localparam logic [1:0] S_LOCKOUT = 2'd3;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   r_failCnt;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_armed;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_deny;
    logic            r_roomAvail;
    logic            r_ajar;
    logic            r_availS;
    logic            r_availD;
    logic            r_unavS;
    logic            r_unavD;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [PW-1:0]   w_sel;
    logic [NREQ-1:0] w_selOh;
    logic            w_arbActive;
    logic            w_serve;
    logic [NREQ-1:0] w_servedOh;
    logic            w_selAdmin;
    logic            w_grantOk;
    logic            w_doGrant;
    logic            w_doDeny;
    logic [FW-1:0]   w_failInc;
    logic [PW-1:0]   w_ptrNext;
    logic            w_availRise;
    logic            w_unavRise;

    assign w_elig      = req & r_armed;
    assign w_availRise = r_availS & ~r_availD;
    assign w_unavRise  = r_unavS & ~r_unavD;

    // Round-robin pick: first eligible requester at or above the pointer,
    // otherwise the first eligible one below it.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_selOh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && 1'(w_elig >> i) && (PW'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_sel   = PW'(i);
                w_selOh = NREQ'(1) << i;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && 1'(w_elig >> i) && (PW'(i) < r_ptr)) begin
                w_found = 1'b1;
                w_sel   = PW'(i);
                w_selOh = NREQ'(1) << i;
            end
        end
    end

    assign w_arbActive = (r_state == S_IDLE) || (r_state == S_LOCKOUT);
    assign w_serve     = w_found && w_arbActive;
    assign w_servedOh  = w_serve ? w_selOh : '0;
    assign w_selAdmin  = |(w_selOh & admin);
    assign w_grantOk   = (r_state == S_IDLE) ? (r_roomAvail || w_selAdmin) : w_selAdmin;
    assign w_doGrant   = w_serve && w_grantOk;
    assign w_doDeny    = w_serve && !w_grantOk;
    assign w_failInc   = (r_failCnt == FAIL_MAX) ? r_failCnt : r_failCnt + FW'(1);
    assign w_ptrNext   = (w_sel == PTR_LAST) ? '0 : w_sel + PW'(1);

    // Booking inputs: one sampling stage, one edge-detect stage; a booking
    // edge beats an availability edge arriving in the same cycle.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!reset_n) begin
            r_availS    <= 1'b0;
            r_availD    <= 1'b0;
            r_unavS     <= 1'b0;
            r_unavD     <= 1'b0;
            r_roomAvail <= 1'b0;
        end else begin
            r_availS <= available;
            r_availD <= r_availS;
            r_unavS  <= unavailable;
            r_unavD  <= r_unavS;
            if (w_unavRise) begin
                r_roomAvail <= 1'b0;
            end else if (w_availRise) begin
                r_roomAvail <= 1'b1;
            end
        end
    end

    // A requester re-arms whenever it lets go of req, and disarms once answered,
    // so a held request is answered only once.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!reset_n) begin
            r_armed <= '1;
        end else begin
            r_armed <= ~req | (r_armed & ~w_servedOh);
        end
    end

    // Answer pulses and the round-robin pointer move together with each service.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!reset_n) begin
            r_grant <= '0;
            r_deny  <= '0;
            r_ptr   <= '0;
        end else begin
            r_grant <= w_doGrant ? w_selOh : '0;
            r_deny  <= w_doDeny ? w_selOh : '0;
            if (w_serve) begin
                r_ptr <= w_ptrNext;
            end
        end
    end

    // Door sequencing: strike window, door-open supervision and lockout timing.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_failCnt <= '0;
            r_ajar    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_doGrant) begin
                        r_state   <= S_UNLOCK;
                        r_cnt     <= '0;
                        r_failCnt <= '0;
                    end else if (w_doDeny) begin
                        r_failCnt <= w_failInc;
                        if (w_failInc == FAIL_MAX) begin
                            r_state <= S_LOCKOUT;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_UNLOCK: begin
                    if (!door_closed) begin
                        r_state <= S_OPEN;
                        r_cnt   <= '0;
                    end else if (r_cnt == UNLOCK_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_OPEN: begin
                    if (door_closed) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_ajar  <= 1'b0;
                    end else if (r_cnt == AJAR_LAST) begin
                        r_ajar <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_LOCKOUT: begin
                    if (w_doGrant) begin
                        r_state   <= S_UNLOCK;
                        r_cnt     <= '0;
                        r_failCnt <= '0;
                    end else if (r_cnt == LOCKOUT_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_failCnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign grant          = r_grant;
    assign deny           = r_deny;
    assign lock_output    = (r_state == S_UNLOCK);
    assign lockout        = (r_state == S_LOCKOUT);
    assign room_available = r_roomAvail;
    assign ajar_alarm     = r_ajar;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Testbench for door_access_ctrl.
// A behavioural model tracks the controller in terms of remaining window
// time, elapsed open time and remaining lockout time, and is compared with
// the DUT every cycle. Directed scenarios with literal expectations pin the
// model; a randomized phase follows.
module tb_door_access_ctrl;

    localparam int NREQ        = 3;
    localparam int UNLOCK_CYC  = 10;
    localparam int AJAR_CYC    = 20;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            available;
    logic            unavailable;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] admin;
    logic            door_closed;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] deny;
    logic            lock_output;
    logic            room_available;
    logic            ajar_alarm;
    logic            lockout;

    int nChecks = 0;
    int nPass   = 0;

    door_access_ctrl #(
        .NREQ        (NREQ),
        .UNLOCK_CYC  (UNLOCK_CYC),
        .AJAR_CYC    (AJAR_CYC),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) dut (
        .FPGA_CLK1_50   (clk),
        .reset_n        (reset_n),
        .available      (available),
        .unavailable    (unavailable),
        .req            (req),
        .admin          (admin),
        .door_closed    (door_closed),
        .grant          (grant),
        .deny           (deny),
        .lock_output    (lock_output),
        .room_available (room_available),
        .ajar_alarm     (ajar_alarm),
        .lockout        (lockout)
    );

    // 50 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive request inputs at a falling edge, then move to the next falling edge.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] a, input logic dc);
        req         = r;
        admin       = a;
        door_closed = dc;
        @(negedge clk);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseBooking(input logic av, input logic un);
        available   = av;
        unavailable = un;
        @(negedge clk);
        available   = 1'b0;
        unavailable = 1'b0;
        stepCycles(3);
    endtask

    // Behavioural model state.
    typedef enum int {M_IDLE, M_STRIKE, M_DOOROPEN, M_LOCKED} modelMode_t;
    modelMode_t      mMode;
    modelMode_t      prevMode;
    int              mPtr;
    int              mFail;
    int              mStrikeLeft;
    int              mOpenFor;
    int              mLockLeft;
    int              served;
    int              mCand;
    logic [NREQ-1:0] mArmed;
    logic [NREQ-1:0] mGrant;
    logic [NREQ-1:0] mDeny;
    bit              mRoom;
    bit              mAlarm;
    bit              mAdm;
    bit              granted;
    bit              mValid = 1'b0;
    bit              avSeen1, avSeen2, unSeen1, unSeen2;
    bit              avRise, unRise;

    // Model update on each rising edge, then compare the DUT against it.
    always @(posedge clk) begin
        if (!reset_n) begin
            mMode       = M_IDLE;
            mPtr        = 0;
            mFail       = 0;
            mStrikeLeft = 0;
            mOpenFor    = 0;
            mLockLeft   = 0;
            mArmed      = '1;
            mGrant      = '0;
            mDeny       = '0;
            mRoom       = 1'b0;
            mAlarm      = 1'b0;
            avSeen1     = 1'b0;
            avSeen2     = 1'b0;
            unSeen1     = 1'b0;
            unSeen2     = 1'b0;
            mValid      = 1'b1;
        end else if (mValid) begin
            prevMode = mMode;
            served   = -1;
            granted  = 1'b0;
            mGrant   = '0;
            mDeny    = '0;
            if (prevMode == M_IDLE || prevMode == M_LOCKED) begin
                for (int k = 0; k < NREQ; k++) begin
                    mCand = (mPtr + k) % NREQ;
                    if (served < 0 && 1'(req >> mCand) && 1'(mArmed >> mCand)) served = mCand;
                end
            end
            if (served >= 0) begin
                mAdm    = 1'(admin >> served);
                granted = (prevMode == M_IDLE) ? (mRoom || mAdm) : mAdm;
                mPtr    = (served + 1) % NREQ;
                if (granted) begin
                    mGrant      = NREQ'(1) << served;
                    mFail       = 0;
                    mMode       = M_STRIKE;
                    mStrikeLeft = UNLOCK_CYC;
                end else begin
                    mDeny = NREQ'(1) << served;
                    if (prevMode == M_IDLE) begin
                        mFail = (mFail < MAX_FAIL) ? mFail + 1 : MAX_FAIL;
                        if (mFail == MAX_FAIL) begin
                            mMode     = M_LOCKED;
                            mLockLeft = LOCKOUT_CYC;
                        end
                    end
                end
            end
            case (prevMode)
                M_STRIKE: begin
                    if (!door_closed) begin
                        mMode    = M_DOOROPEN;
                        mOpenFor = 0;
                    end else if (mStrikeLeft <= 1) begin
                        mMode = M_IDLE;
                    end else begin
                        mStrikeLeft--;
                    end
                end
                M_DOOROPEN: begin
                    if (door_closed) begin
                        mMode  = M_IDLE;
                        mAlarm = 1'b0;
                    end else begin
                        mOpenFor++;
                        if (mOpenFor >= AJAR_CYC) mAlarm = 1'b1;
                    end
                end
                M_LOCKED: begin
                    if (!granted) begin
                        if (mLockLeft <= 1) begin
                            mMode = M_IDLE;
                            mFail = 0;
                        end else begin
                            mLockLeft--;
                        end
                    end
                end
                default: ;
            endcase
            for (int i = 0; i < NREQ; i++) begin
                if (!1'(req >> i)) mArmed = mArmed | (NREQ'(1) << i);
                else if (i == served) mArmed = mArmed & ~(NREQ'(1) << i);
            end
            avRise  = avSeen1 && !avSeen2;
            unRise  = unSeen1 && !unSeen2;
            if (unRise) mRoom = 1'b0;
            else if (avRise) mRoom = 1'b1;
            avSeen2 = avSeen1;
            avSeen1 = available;
            unSeen2 = unSeen1;
            unSeen1 = unavailable;
        end
        #1;
        if (mValid) begin
            checkOutput("model_grant", 32'(grant), 32'(mGrant));
            checkOutput("model_deny", 32'(deny), 32'(mDeny));
            checkOutput("model_lock_output", 32'(lock_output), 32'(mMode == M_STRIKE));
            checkOutput("model_lockout", 32'(lockout), 32'(mMode == M_LOCKED));
            checkOutput("model_room_available", 32'(room_available), 32'(mRoom));
            checkOutput("model_ajar_alarm", 32'(ajar_alarm), 32'(mAlarm));
        end
    end

    int gOrder[$];
    int cnt;
    logic [NREQ-1:0] rq;

    task automatic captureGrants(input int maxCycles);
        gOrder = {};
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (1'(grant >> i)) gOrder.push_back(i);
            end
        end
    endtask

    task automatic threeDenials();
        for (int n = 0; n < 3; n++) begin
            req = 3'b001;
            @(negedge clk);
            checkOutput("lockout_deny_n", 32'(deny), 32'h1);
            req = 3'b000;
            if (n < 2) @(negedge clk);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        reset_n     = 1'b0;
        available   = 1'b0;
        unavailable = 1'b0;
        req         = '0;
        admin       = '0;
        door_closed = 1'b1;
        stepCycles(3);
        checkOutput("reset_grant", 32'(grant), 32'h0);
        checkOutput("reset_deny", 32'(deny), 32'h0);
        checkOutput("reset_lock_output", 32'(lock_output), 32'h0);
        checkOutput("reset_room_available", 32'(room_available), 32'h0);
        checkOutput("reset_ajar_alarm", 32'(ajar_alarm), 32'h0);
        checkOutput("reset_lockout", 32'(lockout), 32'h0);
        reset_n = 1'b1;
        stepCycles(2);

        // Booking and single grant.
        available = 1'b1;
        @(negedge clk);
        checkOutput("booking_latency_early", 32'(room_available), 32'h0);
        available = 1'b0;
        @(negedge clk);
        checkOutput("booking_latency_set", 32'(room_available), 32'h1);
        applyStimulus(3'b010, 3'b000, 1'b1);
        checkOutput("s1_grant", 32'(grant), 32'h2);
        checkOutput("s1_lock_rise", 32'(lock_output), 32'h1);
        cnt = 1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 0) checkOutput("s1_grant_one_cycle", 32'(grant), 32'h0);
            if (lock_output) cnt++;
            else break;
        end
        checkOutput("s1_strike_len", 32'(cnt), 32'd10);
        req = '0;
        stepCycles(2);

        // Round-robin from a fresh pointer.
        reset_n = 1'b0;
        stepCycles(2);
        reset_n = 1'b1;
        pulseBooking(1'b1, 1'b0);
        req = 3'b111;
        captureGrants(60);
        checkOutput("rr1_count", 32'(gOrder.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rr1_order", 32'((i < gOrder.size()) ? gOrder[i] : 99), 32'(i));
        end
        applyStimulus(3'b000, 3'b000, 1'b1);
        req = 3'b111;
        captureGrants(60);
        checkOutput("rr2_count", 32'(gOrder.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rr2_order", 32'((i < gOrder.size()) ? gOrder[i] : 99), 32'(i));
        end
        applyStimulus(3'b000, 3'b000, 1'b1);

        // Lockout after repeated refusals.
        pulseBooking(1'b0, 1'b1);
        checkOutput("s3_room_booked", 32'(room_available), 32'h0);
        threeDenials();
        checkOutput("s3_lockout_on", 32'(lockout), 32'h1);
        cnt = 1;
        for (int j = 0; j < 40; j++) begin
            if (j == 2) req = 3'b010;
            @(negedge clk);
            if (j == 2) begin
                checkOutput("s3_deny_in_lockout", 32'(deny), 32'h2);
                req = 3'b000;
            end
            if (lockout) cnt++;
            else break;
        end
        checkOutput("s3_lockout_len", 32'(cnt), 32'd16);
        threeDenials();
        checkOutput("s3_lockout_again", 32'(lockout), 32'h1);
        applyStimulus(3'b100, 3'b100, 1'b1);
        checkOutput("s3_admin_grant", 32'(grant), 32'h4);
        checkOutput("s3_admin_lock", 32'(lock_output), 32'h1);
        checkOutput("s3_admin_lockout_off", 32'(lockout), 32'h0);
        req   = '0;
        admin = '0;
        stepCycles(12);
        checkOutput("s3_window_done", 32'(lock_output), 32'h0);

        // Door held open until the ajar alarm.
        applyStimulus(3'b001, 3'b001, 1'b1);
        checkOutput("s4_grant", 32'(grant), 32'h1);
        req   = '0;
        admin = '0;
        stepCycles(2);
        checkOutput("s4_lock_cycle3", 32'(lock_output), 32'h1);
        door_closed = 1'b0;
        @(negedge clk);
        checkOutput("s4_strike_drop", 32'(lock_output), 32'h0);
        checkOutput("s4_no_alarm_yet", 32'(ajar_alarm), 32'h0);
        cnt = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            cnt++;
            if (ajar_alarm) break;
        end
        checkOutput("s4_ajar_delay", 32'(cnt), 32'd20);
        door_closed = 1'b1;
        @(negedge clk);
        checkOutput("s4_ajar_clear", 32'(ajar_alarm), 32'h0);
        checkOutput("s4_lock_idle", 32'(lock_output), 32'h0);
        stepCycles(2);

        // Simultaneous booking edges.
        pulseBooking(1'b1, 1'b0);
        checkOutput("s5_room_set", 32'(room_available), 32'h1);
        pulseBooking(1'b1, 1'b1);
        checkOutput("s5_unavailable_wins", 32'(room_available), 32'h0);

        // Reset in the middle of a strike window.
        pulseBooking(1'b1, 1'b0);
        applyStimulus(3'b100, 3'b000, 1'b1);
        checkOutput("s6_grant", 32'(grant), 32'h4);
        stepCycles(4);
        checkOutput("s6_lock_cycle5", 32'(lock_output), 32'h1);
        reset_n = 1'b0;
        req     = '0;
        @(negedge clk);
        checkOutput("s6_rst_lock", 32'(lock_output), 32'h0);
        checkOutput("s6_rst_room", 32'(room_available), 32'h0);
        checkOutput("s6_rst_grant", 32'(grant), 32'h0);
        checkOutput("s6_rst_deny", 32'(deny), 32'h0);
        checkOutput("s6_rst_ajar", 32'(ajar_alarm), 32'h0);
        checkOutput("s6_rst_lockout", 32'(lockout), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(3'b001, 3'b000, 1'b1);
        checkOutput("s6_deny_after_reset", 32'(deny), 32'h1);
        checkOutput("s6_no_grant_after_reset", 32'(grant), 32'h0);
        req = '0;
        stepCycles(2);

        // Randomized traffic checked by the model.
        rq = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (1'(rq >> i)) begin
                    if ($urandom_range(3) == 0) rq = rq & ~(NREQ'(1) << i);
                end else if ($urandom_range(5) == 0) begin
                    rq = rq | (NREQ'(1) << i);
                end
            end
            req   = rq;
            admin = NREQ'($urandom) & NREQ'($urandom);
            if ($urandom_range(15) == 0) available = ~available;
            if ($urandom_range(15) == 0) unavailable = ~unavailable;
            if (door_closed) begin
                if ($urandom_range(11) == 0) door_closed = 1'b0;
            end else if ($urandom_range(19) == 0) begin
                door_closed = 1'b1;
            end
            reset_n = ($urandom_range(299) != 0);
            @(negedge clk);
        end

        reset_n     = 1'b1;
        req         = '0;
        admin       = '0;
        door_closed = 1'b1;
        stepCycles(5);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
